// File: rtl/umultiplier_seq.sv
// -----------------------------------------------------------------------------
// umultiplier_seq
//
// Sequential unsigned multiply / multiply-accumulate unit. A WIDTH x WIDTH
// product is formed by radix-2 shift-add over WIDTH cycles. The product can
// then replace, be added to, or be subtracted from an internal 2*WIDTH
// accumulator. Operations are requested with a start/busy/done handshake.
//
// Ports:
//   clk      in   1         clock, all state changes on the rising edge
//   rst      in   1         synchronous active-high reset
//   start    in   1         request, only sampled while busy=0
//   mode     in   2         00 MUL, 01 MAC_ADD, 10 MAC_SUB, 11 CLR
//   a        in   WIDTH     multiplicand (unsigned), latched on accepted start
//   b        in   WIDTH     multiplier (unsigned), latched on accepted start
//   busy     out  1         high while an operation is in progress
//   done     out  1         one-cycle pulse, product/ovf valid in this cycle
//   product  out  2*WIDTH   result register, held until the next done
//   ovf      out  1         carry (MAC_ADD) or borrow (MAC_SUB), else 0
// -----------------------------------------------------------------------------
module umultiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [PW:0]   ONE  = 1;

    localparam logic [1:0] MODE_MUL = 2'b00;
    localparam logic [1:0] MODE_ADD = 2'b01;
    localparam logic [1:0] MODE_SUB = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t          state;
    logic [1:0]      mode_lat;
    logic [PW-1:0]   a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [PW-1:0]   p;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic [PW:0]     sum_add;
    logic [PW:0]     sum_sub;

    // Accumulate step. Subtraction is acc + ~P + 1; its carry out is the
    // inverse of the borrow, so ovf for MAC_SUB is the complement.
    always_comb begin
        sum_add = {1'b0, acc} + {1'b0, p};
        sum_sub = {1'b0, acc} + {1'b0, ~p} + ONE;
    end

    // Control and datapath. Instead of indexing b with the counter and
    // shifting a by it, b is shifted right and a left each iteration, so
    // iteration i sees b_lat[i] in b_sh[0] and a_lat << i in a_sh.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            product  <= '0;
            acc      <= '0;
            p        <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            mode_lat <= MODE_MUL;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == MODE_CLR) begin
                            acc     <= '0;
                            product <= '0;
                            ovf     <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            mode_lat <= mode;
                            a_sh     <= {{WIDTH{1'b0}}, a};
                            b_sh     <= b;
                            p        <= '0;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (b_sh[0]) begin
                        p <= p + a_sh;
                    end
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    case (mode_lat)
                        MODE_MUL: begin
                            product <= p;
                            acc     <= p;
                            ovf     <= 1'b0;
                        end
                        MODE_ADD: begin
                            product <= sum_add[PW-1:0];
                            acc     <= sum_add[PW-1:0];
                            ovf     <= sum_add[PW];
                        end
                        MODE_SUB: begin
                            product <= sum_sub[PW-1:0];
                            acc     <= sum_sub[PW-1:0];
                            ovf     <= ~sum_sub[PW];
                        end
                        default: begin
                            product <= '0;
                            acc     <= '0;
                            ovf     <= 1'b0;
                        end
                    endcase
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_umultiplier_seq.sv
// -----------------------------------------------------------------------------
// tb_umultiplier_seq
//
// Self-checking bench for umultiplier_seq. One instance at WIDTH=8 runs a
// table of directed operations, hand-written multi-cycle corner cases and
// random operations; a second instance at WIDTH=32 is hammered with start
// every cycle. Expected results come from a plain-arithmetic model.
// -----------------------------------------------------------------------------
module tb_umultiplier_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        rst8, start8, busy8, done8, ovf8;
    logic [1:0]  mode8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    // WIDTH=32 instance
    logic        rst32, start32, busy32, done32, ovf32;
    logic [1:0]  mode32;
    logic [31:0] a32, b32;
    logic [63:0] prod32;

    umultiplier_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst8), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8), .ovf(ovf8)
    );

    umultiplier_seq #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst32), .start(start32), .mode(mode32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .product(prod32), .ovf(ovf32)
    );

    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        logic [1:0]  m;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] ep;
        logic        eo;
    } vec_t;

    typedef struct {
        logic [63:0] p;
        logic        o;
    } res_t;

    vec_t tbl[10];
    res_t q32[$];

    logic [63:0] acc8, acc32;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: plain modular arithmetic on a 2*w-bit accumulator.
    task automatic model(input int w, input logic [1:0] m, input logic [31:0] x,
                         input logic [31:0] y, inout logic [63:0] acc,
                         output logic [63:0] p, output logic o);
        logic [64:0] mask;
        logic [64:0] s;
        logic [63:0] prd;
        mask = (65'd1 << (2 * w)) - 65'd1;
        prd  = 64'(x) * 64'(y);
        case (m)
            2'd0: begin p = prd; o = 1'b0; end
            2'd1: begin
                s = {1'b0, acc} + {1'b0, prd};
                o = s[2 * w];
                p = s[63:0] & mask[63:0];
            end
            2'd2: begin
                o = (acc < prd);
                p = (acc - prd) & mask[63:0];
            end
            default: begin p = 64'd0; o = 1'b0; end
        endcase
        acc = p;
    endtask

    // Issue one operation on the 8-bit unit (called at a negedge) and follow
    // it until done, returning latency and number of busy cycles seen.
    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y,
                                 output logic [15:0] p, output logic o,
                                 output int lat, output int bc);
        start8 = 1'b1; mode8 = m; a8 = x; b8 = y;
        lat = 0; bc = 0; p = '0; o = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (busy8) bc++;
            if (done8) begin
                lat = k; p = prod8; o = ovf8;
                break;
            end
        end
    endtask

    task automatic checkOutput(input string nm, input logic [1:0] m,
                               input logic [15:0] p, input logic o, input int lat,
                               input int bc, input logic [15:0] ep, input logic eo);
        chk({nm, ".product"}, 64'(p), 64'(ep));
        chk({nm, ".ovf"}, 64'(o), 64'(eo));
        chk({nm, ".latency"}, 64'(lat), (m == 2'd3) ? 64'd1 : 64'd10);
        chk({nm, ".busy_cycles"}, 64'(bc), (m == 2'd3) ? 64'd0 : 64'd9);
    endtask

    task automatic countDone8(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done8) cnt++;
        end
    endtask

    initial begin
        logic [15:0] p;
        logic        o;
        int          lat, bc, nd;
        logic [63:0] mp;
        logic        mo;
        logic [1:0]  rm;
        logic [7:0]  rx, ry;

        tbl[0] = '{2'd0, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
        tbl[1] = '{2'd1, 8'hFF, 8'hFF, 16'hFC02, 1'b1};
        tbl[2] = '{2'd3, 8'h5A, 8'hA5, 16'h0000, 1'b0};
        tbl[3] = '{2'd0, 8'h03, 8'h05, 16'h000F, 1'b0};
        tbl[4] = '{2'd1, 8'h02, 8'h04, 16'h0017, 1'b0};
        tbl[5] = '{2'd2, 8'h10, 8'h10, 16'hFF17, 1'b1};
        tbl[6] = '{2'd0, 8'h00, 8'hAA, 16'h0000, 1'b0};
        tbl[7] = '{2'd0, 8'hAA, 8'h00, 16'h0000, 1'b0};
        tbl[8] = '{2'd1, 8'h07, 8'h09, 16'h003F, 1'b0};
        tbl[9] = '{2'd2, 8'h00, 8'hAA, 16'h003F, 1'b0};

        rst8 = 1'b1; start8 = 1'b0; mode8 = '0; a8 = '0; b8 = '0;
        rst32 = 1'b1; start32 = 1'b0; mode32 = '0; a32 = '0; b32 = '0;
        acc8 = '0; acc32 = '0;
        repeat (3) @(negedge clk);
        chk("reset8.busy", 64'(busy8), 64'd0);
        chk("reset8.done", 64'(done8), 64'd0);
        chk("reset8.product", 64'(prod8), 64'd0);
        chk("reset8.ovf", 64'(ovf8), 64'd0);
        chk("reset32.busy", 64'(busy32), 64'd0);
        chk("reset32.product", prod32, 64'd0);
        rst8 = 1'b0; rst32 = 1'b0;
        @(negedge clk);

        // Directed table, issued back to back (each start in the done cycle)
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].m, tbl[i].x, tbl[i].y, p, o, lat, bc);
            checkOutput($sformatf("tbl%0d", i), tbl[i].m, p, o, lat, bc, tbl[i].ep, tbl[i].eo);
            model(8, tbl[i].m, 32'(tbl[i].x), 32'(tbl[i].y), acc8, mp, mo);
        end

        // Back-to-back CLR: done high in two consecutive cycles
        start8 = 1'b1; mode8 = 2'd3;
        @(negedge clk);
        chk("clr2.done1", 64'(done8), 64'd1);
        @(negedge clk);
        start8 = 1'b0;
        chk("clr2.done2", 64'(done8), 64'd1);
        chk("clr2.busy", 64'(busy8), 64'd0);
        acc8 = '0;

        // Start pulsed while busy must be ignored
        start8 = 1'b1; mode8 = 2'd0; a8 = 8'h12; b8 = 8'h34;
        lat = 0; p = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done8) begin lat = k; p = prod8; break; end
            start8 = (k == 3);
            mode8 = 2'd1; a8 = 8'hFF; b8 = 8'hFF;
        end
        start8 = 1'b0;
        chk("busy_start.product", 64'(p), 64'h3A8);
        chk("busy_start.latency", 64'(lat), 64'd10);
        countDone8(14, nd);
        chk("busy_start.no_extra_done", 64'(nd), 64'd0);
        model(8, 2'd0, 32'h12, 32'h34, acc8, mp, mo);

        // Reset during RUN cycle 4 aborts the operation
        start8 = 1'b1; mode8 = 2'd0; a8 = 8'h55; b8 = 8'h66;
        nd = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) nd++;
        end
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("abort.busy", 64'(busy8), 64'd0);
        chk("abort.done", 64'(done8), 64'd0);
        chk("abort.product", 64'(prod8), 64'd0);
        chk("abort.ovf", 64'(ovf8), 64'd0);
        countDone8(14, lat);
        chk("abort.no_done", 64'(nd + lat), 64'd0);
        acc8 = '0;
        applyStimulus(2'd1, 8'h01, 8'h01, p, o, lat, bc);
        checkOutput("abort.mac_add", 2'd1, p, o, lat, bc, 16'h0001, 1'b0);
        model(8, 2'd1, 32'h1, 32'h1, acc8, mp, mo);

        // Reset and start in the same cycle: reset wins
        rst8 = 1'b1; start8 = 1'b1; mode8 = 2'd1; a8 = 8'h03; b8 = 8'h03;
        @(negedge clk);
        rst8 = 1'b0; start8 = 1'b0;
        chk("rst_start.busy", 64'(busy8), 64'd0);
        countDone8(14, nd);
        chk("rst_start.no_done", 64'(nd), 64'd0);
        chk("rst_start.product", 64'(prod8), 64'd0);
        acc8 = '0;

        // Random operations on the 8-bit unit against the model
        for (int i = 0; i < 20; i++) begin
            rm = 2'($urandom_range(0, 3));
            rx = 8'($urandom);
            ry = 8'($urandom);
            if (i % 5 == 0) ry = 8'hFF;
            applyStimulus(rm, rx, ry, p, o, lat, bc);
            model(8, rm, 32'(rx), 32'(ry), acc8, mp, mo);
            checkOutput($sformatf("rnd8_%0d", i), rm, p, o, lat, bc, mp[15:0], mo);
        end

        // 32-bit unit with start every cycle: only every 34th start accepted
        for (int c = 0; c <= 5 * 34; c++) begin
            chk($sformatf("w32.done@%0d", c), 64'(done32), (c > 0 && c % 34 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("w32.busy@%0d", c), 64'(busy32), (c % 34 != 0) ? 64'd1 : 64'd0);
            if (c > 0 && c % 34 == 0) begin
                if (q32.size() == 0) begin
                    chk("w32.queue_empty", 64'd1, 64'd0);
                end else begin
                    res_t r;
                    r = q32.pop_front();
                    chk($sformatf("w32.product@%0d", c), prod32, r.p);
                    chk($sformatf("w32.ovf@%0d", c), 64'(ovf32), 64'(r.o));
                end
            end
            if (c < 5 * 34) begin
                start32 = 1'b1;
                mode32 = 2'($urandom_range(0, 2));
                a32 = $urandom;
                b32 = $urandom;
                if (c % 34 == 0) begin
                    res_t r;
                    model(32, mode32, a32, b32, acc32, r.p, r.o);
                    q32.push_back(r);
                end
            end else begin
                start32 = 1'b0;
            end
            @(negedge clk);
        end
        start32 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
